// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe
//   Pipelined segmented adder with a runtime approximation level. The operands
//   are split into NSEG = WIDTH/SEG segments, one pipeline stage per segment.
//   The lowest lvl segments use a cheap OR/AND rule and the rest add exactly.
//   An exact shadow chain runs alongside, so every result can be flagged when
//   it differs from the true sum. Flagged results are counted in a saturating
//   counter.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction valid
//   in_ready   pipeline can accept (combinational: ~out_valid | out_ready)
//   in_a/in_b  operands, WIDTH bits
//   in_lvl     number of low segments computed approximately (clamped to NSEG)
//   out_valid  result valid
//   out_ready  downstream accepts
//   out_sum    approximate sum, WIDTH+1 bits, MSB = final carry
//   out_err    result differs from the exact sum
//   err_cnt    saturating count of delivered results with out_err set
//   err_clr    synchronous clear of err_cnt, wins over an increment
module approx_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int ERRW  = 16,
  parameter int LVLW  = $clog2(WIDTH/SEG+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [LVLW-1:0]  in_lvl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  output logic [ERRW-1:0]  err_cnt,
  input  logic             err_clr
);

  localparam int NSEG = WIDTH / SEG;

  // Stage s registers hold the transaction after segment s has been processed:
  // sa/se carry the finished approximate/exact low segments, ca/ce the carries
  // into segment s+1, and a/b/lvl the skewed operands for the later stages.
  logic [NSEG-1:0]  vld_q, vld_d;
  logic [NSEG-1:0]  ca_q, ca_d;
  logic [NSEG-1:0]  ce_q, ce_d;
  logic [LVLW-1:0]  lvl_q [NSEG];
  logic [LVLW-1:0]  lvl_d [NSEG];
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];
  logic [WIDTH-1:0] sa_q  [NSEG];
  logic [WIDTH-1:0] sa_d  [NSEG];
  logic [WIDTH-1:0] se_q  [NSEG];
  logic [WIDTH-1:0] se_d  [NSEG];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   out_sum_q, out_sum_d;
  logic             out_err_q, out_err_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

  logic             adv;
  logic [LVLW-1:0]  lvl_in;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign lvl_in   = (in_lvl > LVLW'(NSEG)) ? LVLW'(NSEG) : in_lvl;

  always_comb begin
    logic             t_v;
    logic [LVLW-1:0]  t_l;
    logic [WIDTH-1:0] t_a, t_b, t_sa, t_se;
    logic             t_ca, t_ce;
    logic [SEG:0]     ex, ap;

    t_v = 1'b0; t_l = '0; t_a = '0; t_b = '0; t_sa = '0; t_se = '0;
    t_ca = 1'b0; t_ce = 1'b0; ex = '0; ap = '0;
    vld_d = vld_q;
    ca_d  = ca_q;
    ce_d  = ce_q;
    for (int s = 0; s < NSEG; s++) begin
      lvl_d[s] = lvl_q[s];
      a_d[s]   = a_q[s];
      b_d[s]   = b_q[s];
      sa_d[s]  = sa_q[s];
      se_d[s]  = se_q[s];
    end

    if (adv) begin
      for (int s = 0; s < NSEG; s++) begin
        if (s == 0) begin
          t_v = in_valid; t_l = lvl_in; t_a = in_a; t_b = in_b;
          t_sa = '0; t_se = '0; t_ca = 1'b0; t_ce = 1'b0;
        end else begin
          t_v = vld_q[s-1]; t_l = lvl_q[s-1]; t_a = a_q[s-1]; t_b = b_q[s-1];
          t_sa = sa_q[s-1]; t_se = se_q[s-1]; t_ca = ca_q[s-1]; t_ce = ce_q[s-1];
        end

        ex = {1'b0, t_a[s*SEG +: SEG]} + {1'b0, t_b[s*SEG +: SEG]} + {{SEG{1'b0}}, t_ce};
        t_se[s*SEG +: SEG] = ex[SEG-1:0];
        t_ce = ex[SEG];

        if (s < int'(t_l)) begin
          // Approximate: no carry-in, carry-out guessed from the segment MSBs.
          t_sa[s*SEG +: SEG] = t_a[s*SEG +: SEG] | t_b[s*SEG +: SEG];
          t_ca = t_a[s*SEG+SEG-1] & t_b[s*SEG+SEG-1];
        end else begin
          ap = {1'b0, t_a[s*SEG +: SEG]} + {1'b0, t_b[s*SEG +: SEG]} + {{SEG{1'b0}}, t_ca};
          t_sa[s*SEG +: SEG] = ap[SEG-1:0];
          t_ca = ap[SEG];
        end

        vld_d[s] = t_v;
        lvl_d[s] = t_l;
        a_d[s]   = t_a;
        b_d[s]   = t_b;
        sa_d[s]  = t_sa;
        se_d[s]  = t_se;
        ca_d[s]  = t_ca;
        ce_d[s]  = t_ce;
      end
    end
  end

  // Output stage: the last pipeline rank is compared against its exact shadow
  // here so that out_err comes straight from a flop.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    if (adv) begin
      out_valid_d = vld_q[NSEG-1];
      if (vld_q[NSEG-1]) begin
        out_sum_d = {ca_q[NSEG-1], sa_q[NSEG-1]};
        out_err_d = ({ca_q[NSEG-1], sa_q[NSEG-1]} != {ce_q[NSEG-1], se_q[NSEG-1]});
      end
    end

    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_valid_q & out_ready & out_err_q & ~(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      ca_q        <= '0;
      ce_q        <= '0;
      for (int s = 0; s < NSEG; s++) begin
        lvl_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sa_q[s]  <= '0;
        se_q[s]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      vld_q       <= vld_d;
      ca_q        <= ca_d;
      ce_q        <= ce_d;
      for (int s = 0; s < NSEG; s++) begin
        lvl_q[s] <= lvl_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sa_q[s]  <= sa_d[s];
        se_q[s]  <= se_d[s];
      end
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
